miriscv_lsu_axil_bridge: RTL

MIRISCV_LSU_AXIL_BRIDGE -- requirements
Module: miriscv_lsu_axil_bridge

---
 rtl/miriscv_axil_pkg.sv | 42 ++++
 rtl/miriscv_pkg.sv | 10 +
 rtl/miriscv_lsu_axil_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_axil_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_axil_pkg
// Types and constants for the LSU to AXI4-Lite bridge.
//   axil_state_e   : bridge FSM states
//   AXI_RESP_*     : AXI response encodings
//   axil_resp_err  : maps a BRESP/RRESP code to the LSU error flag
// ---------------------------------------------------------------------------
package miriscv_axil_pkg;

    // IDLE     : waiting for an LSU request
    // WR       : AW and/or W still outstanding
    // WAIT_B   : both write channels done, waiting for the write response
    // RD_A     : AR outstanding
    // WAIT_R   : waiting for read data
    // RESP     : one-cycle completion pulse back to the LSU
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_RD_A   = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RESP   = 3'd5
    } axil_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than OKAY is an error; EXOKAY (2'b01) has no meaning on
    // AXI4-Lite and is reported as an error as well.
    function automatic logic axil_resp_err(input logic [1:0] resp);
        logic is_err;
        case (resp)
            AXI_RESP_OKAY:   is_err = 1'b0;
            AXI_RESP_SLVERR,
            AXI_RESP_DECERR: is_err = 1'b1;
            default:         is_err = 1'b1;
        endcase
        return is_err;
    endfunction

endpackage : miriscv_axil_pkg

// File: rtl/miriscv_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_pkg
// Core-wide constants shared by the miriscv pipeline and its bus bridges.
//   XLEN : architectural register / data / address width in bits.
// ---------------------------------------------------------------------------
package miriscv_pkg;

    localparam int XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_lsu_axil_bridge.sv
// ---------------------------------------------------------------------------
// miriscv_lsu_axil_bridge
// Converts single LSU data requests into AXI4-Lite transactions, one at a
// time. A request is captured in IDLE, issued on AW+W (store) or AR (load),
// and completed by a single data_rvalid_o pulse carrying the error flag and,
// for loads, the read data.
//
// Parameters
//   AXI_PROT      : value driven on m_awprot / m_arprot
// Ports
//   clk_i, arstn_i            : clock, asynchronous active-low reset
//   data_req_i/we/be/addr/wdata : LSU request (sampled only in IDLE)
//   data_rvalid_o/rdata_o/err_o : LSU completion (pulse, data, error)
//   m_aw*, m_w*, m_b*          : AXI4-Lite write channels
//   m_ar*, m_r*                : AXI4-Lite read channels
// ---------------------------------------------------------------------------
module miriscv_lsu_axil_bridge
    import miriscv_pkg::*, miriscv_axil_pkg::*;
#(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic                clk_i,
    input  logic                arstn_i,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o,
    output logic                data_err_o,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [XLEN-1:0]     m_awaddr,
    output logic [2:0]          m_awprot,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [XLEN-1:0]     m_wdata,
    output logic [XLEN/8-1:0]   m_wstrb,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [XLEN-1:0]     m_araddr,
    output logic [2:0]          m_arprot,

    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [XLEN-1:0]     m_rdata,
    input  logic [1:0]          m_rresp
);

    localparam int STRB_W = XLEN / 8;

    // Word-aligns the captured address; the byte offset lives in the strobes.
    localparam logic [XLEN-1:0] ADDR_WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    axil_state_e        state_q, state_d;

    logic               we_q, we_d;
    logic [STRB_W-1:0]  be_q, be_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               err_q, err_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;

    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               bready_q, bready_d;
    logic               rready_q, rready_d;
    logic               rvalid_q, rvalid_d;

    logic               aw_hs;
    logic               w_hs;
    logic               ar_hs;
    logic               resp_hs;
    logic [1:0]         resp_code;

    assign aw_hs     = awvalid_q & m_awready;
    assign w_hs      = wvalid_q  & m_wready;
    assign ar_hs     = arvalid_q & m_arready;

    // bready/rready are mutually exclusive, so one response event and the
    // captured direction are enough to pick the right response code.
    assign resp_hs   = (bready_q & m_bvalid) | (rready_q & m_rvalid);
    assign resp_code = we_q ? m_bresp : m_rresp;

    // State and datapath registers. Reset clears everything, which abandons
    // any transaction in flight without a completion pulse.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Next-state and datapath capture. data_req_i is only looked at in IDLE,
    // so a request dropped after capture (pipeline kill) still completes.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    we_d      = data_we_i;
                    be_d      = data_be_i;
                    addr_d    = data_addr_i & ADDR_WORD_MASK;
                    wdata_d   = data_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = data_we_i ? ST_WR : ST_RD_A;
                end
            end

            ST_WR: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                if (resp_hs) begin
                    err_d   = axil_resp_err(resp_code);
                    state_d = ST_RESP;
                end
            end

            ST_RD_A: begin
                if (ar_hs) begin
                    state_d = ST_WAIT_R;
                end
            end

            ST_WAIT_R: begin
                if (resp_hs) begin
                    err_d   = axil_resp_err(resp_code);
                    rdata_d = m_rdata;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. Decoding the *next* state and registering the result
    // keeps every AXI valid/ready a plain flop output. A valid only falls
    // once its own done flag is set, i.e. after its handshake.
    always_comb begin
        awvalid_d = (state_d == ST_WR) && !aw_done_d;
        wvalid_d  = (state_d == ST_WR) && !w_done_d;
        arvalid_d = (state_d == ST_RD_A);
        bready_d  = (state_d == ST_WAIT_B);
        rready_d  = (state_d == ST_WAIT_R);
        rvalid_d  = (state_d == ST_RESP);
    end

    assign m_awvalid     = awvalid_q;
    assign m_awaddr      = addr_q;
    assign m_awprot      = AXI_PROT;

    assign m_wvalid      = wvalid_q;
    assign m_wdata       = wdata_q;
    assign m_wstrb       = be_q;

    assign m_bready      = bready_q;

    assign m_arvalid     = arvalid_q;
    assign m_araddr      = addr_q;
    assign m_arprot      = AXI_PROT;

    assign m_rready      = rready_q;

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

endmodule : miriscv_lsu_axil_bridge
